// File: rtl/window_stats.sv
`default_nettype none
// ============================================================================
//  Module      : window_stats
//  Description : Reads one POPSIZE-entry window from the population register
//                file after each new_data pulse. Reduces the window to sum,
//                min/max (with indices) and the count of samples above a
//                threshold. Results are presented with a one-cycle stats_vld
//                strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module window_stats #(
    parameter  int POPSIZE    = 100,
    parameter  int DATA_WIDTH = 8,
    localparam int SUM_W      = DATA_WIDTH + $clog2(POPSIZE),
    localparam int CNT_W      = $clog2(POPSIZE + 1),
    localparam int IDX_W      = $clog2(POPSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_data,
    input  logic                  data_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  rd_rqst,
    output logic [IDX_W-1:0]      read_addr,
    output logic                  busy,
    output logic                  stats_vld,
    output logic [SUM_W-1:0]      sum_out,
    output logic [DATA_WIDTH-1:0] min_out,
    output logic [IDX_W-1:0]      min_idx,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic [IDX_W-1:0]      max_idx,
    output logic [CNT_W-1:0]      cnt_above,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(POPSIZE - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_start;
    logic                    w_acc_en;
    logic                    w_busy;
    logic                    w_rd_rqst;
    logic                    w_stats_vld;

    logic                    r_pending;
    logic                    r_overrun;
    logic [DATA_WIDTH-1:0]   r_thresh;
    logic [IDX_W-1:0]        r_rd_idx;
    logic [IDX_W-1:0]        r_acc_idx;

    // running accumulators for the pass in progress
    logic [SUM_W-1:0]        r_sum;
    logic [DATA_WIDTH-1:0]   r_min;
    logic [IDX_W-1:0]        r_min_idx;
    logic [DATA_WIDTH-1:0]   r_max;
    logic [IDX_W-1:0]        r_max_idx;
    logic [CNT_W-1:0]        r_cnt;

    // accumulator values including the sample arriving this cycle
    logic [SUM_W-1:0]        w_sum_nxt;
    logic [DATA_WIDTH-1:0]   w_min_nxt;
    logic [IDX_W-1:0]        w_min_idx_nxt;
    logic [DATA_WIDTH-1:0]   w_max_nxt;
    logic [IDX_W-1:0]        w_max_idx_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    // published results, held between DONE states
    logic [SUM_W-1:0]        r_sum_out;
    logic [DATA_WIDTH-1:0]   r_min_out;
    logic [IDX_W-1:0]        r_min_idx_out;
    logic [DATA_WIDTH-1:0]   r_max_out;
    logic [IDX_W-1:0]        r_max_idx_out;
    logic [CNT_W-1:0]        r_cnt_out;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and state-decoded controls
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rd_rqst   = 1'b0;
        w_busy      = 1'b1;
        w_stats_vld = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (new_data || r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_rqst = 1'b1;
                w_acc_en  = data_vld;
                if (r_rd_idx == c_last_idx) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_acc_en    = data_vld;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_stats_vld = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // one queued request is allowed while busy; any further one is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (new_data && w_busy) begin
            if (!r_pending) begin
                r_pending <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end
    end

    // fold the incoming sample into the running statistics
    always_comb begin
        w_sum_nxt     = r_sum;
        w_min_nxt     = r_min;
        w_min_idx_nxt = r_min_idx;
        w_max_nxt     = r_max;
        w_max_idx_nxt = r_max_idx;
        w_cnt_nxt     = r_cnt;
        if (w_acc_en) begin
            w_sum_nxt = r_sum + SUM_W'(data_in);
            if (data_in < r_min) begin
                w_min_nxt     = data_in;
                w_min_idx_nxt = r_acc_idx;
            end
            if (data_in > r_max) begin
                w_max_nxt     = data_in;
                w_max_idx_nxt = r_acc_idx;
            end
            if (data_in > r_thresh) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // pass initialisation, address generation and accumulator update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thresh  <= '0;
            r_rd_idx  <= '0;
            r_acc_idx <= '0;
            r_sum     <= '0;
            r_min     <= '0;
            r_min_idx <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_cnt     <= '0;
        end else if (w_start) begin
            r_thresh  <= thresh;
            r_rd_idx  <= '0;
            r_acc_idx <= '0;
            r_sum     <= '0;
            r_min     <= '1;
            r_min_idx <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_sum     <= w_sum_nxt;
            r_min     <= w_min_nxt;
            r_min_idx <= w_min_idx_nxt;
            r_max     <= w_max_nxt;
            r_max_idx <= w_max_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_acc_en) begin
                r_acc_idx <= r_acc_idx + IDX_W'(1);
            end
            if (w_rd_rqst) begin
                r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
        end
    end

    // publish results on the DRAIN->DONE edge, including the final sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_out     <= '0;
            r_min_out     <= '0;
            r_min_idx_out <= '0;
            r_max_out     <= '0;
            r_max_idx_out <= '0;
            r_cnt_out     <= '0;
        end else if (r_state == S_DRAIN) begin
            r_sum_out     <= w_sum_nxt;
            r_min_out     <= w_min_nxt;
            r_min_idx_out <= w_min_idx_nxt;
            r_max_out     <= w_max_nxt;
            r_max_idx_out <= w_max_idx_nxt;
            r_cnt_out     <= w_cnt_nxt;
        end
    end

    assign rd_rqst   = w_rd_rqst;
    assign read_addr = r_rd_idx;
    assign busy      = w_busy;
    assign stats_vld = w_stats_vld;
    assign sum_out   = r_sum_out;
    assign min_out   = r_min_out;
    assign min_idx   = r_min_idx_out;
    assign max_out   = r_max_out;
    assign max_idx   = r_max_idx_out;
    assign cnt_above = r_cnt_out;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
